// File: rtl/ahb_multi_arbiter.sv
// ahb_multi_arbiter: registered N-manager AHB bus arbiter.
//   Fixed-priority (MODE=0, index 0 highest) or round-robin (MODE=1) winner
//   selection. The owner keeps the grant across bursts and locked sequences.
//   Handover happens only on edges with HREADY=1. An optional beat limit
//   (MAXBEATS) forces an unlocked owner off the bus when others are waiting.
// Ports:
//   HCLK, HRESETn - clock, asynchronous active-low reset
//   Req, Lock     - per-manager request and HMASTLOCK
//   HREADY        - shared bus ready, qualifies every state change
//   Grant         - registered one-hot grant, zero when idle
//   GrantValid    - registered |Grant
//   GrantIdx      - registered binary owner index, holds while idle
//   Handover      - one-cycle pulse after a direct owner-to-owner change
module ahb_multi_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MODE     = 0,
  parameter int unsigned MAXBEATS = 16,
  parameter int unsigned IDXW     = $clog2(N)
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic [N-1:0]    Req,
  input  logic [N-1:0]    Lock,
  input  logic            HREADY,
  output logic [N-1:0]    Grant,
  output logic            GrantValid,
  output logic [IDXW-1:0] GrantIdx,
  output logic            Handover
);

  localparam int unsigned CW = (MAXBEATS > 1) ? $clog2(MAXBEATS) : 1;
  localparam logic [CW-1:0] CntMax = CW'((MAXBEATS > 0) ? MAXBEATS - 1 : 0);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e          state_q;
  logic [IDXW-1:0] ptr_q;
  logic [CW-1:0]   beat_q;

  logic            owner_req, owner_lock, others_req;
  logic            limit_hit, do_release;
  logic [N-1:0]    cand;
  logic            win_found;
  logic [IDXW-1:0] win_idx;
  logic [N-1:0]    win_oh;
  logic [IDXW-1:0] ptr_next;

  // Grant is one-hot in OWNED, so it doubles as the owner mask.
  always_comb begin
    owner_req  = |(Req & Grant);
    owner_lock = |(Lock & Grant);
    others_req = |(Req & ~Grant);
    limit_hit  = (MAXBEATS != 0) && (beat_q == CntMax) && !owner_lock && others_req;
    do_release = (!owner_req && !owner_lock) || limit_hit;
    // A forced release must not hand the bus straight back to the owner.
    cand = (state_q == StOwned && limit_hit) ? (Req & ~Grant) : Req;
  end

  // Winner: lowest set bit overall, then (round-robin) lowest set bit at or
  // above the pointer overrides it if one exists.
  always_comb begin
    win_found = |cand;
    win_idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (cand[i]) win_idx = IDXW'(i);
    end
    if (MODE == 1) begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (cand[i] && i >= int'(ptr_q)) win_idx = IDXW'(i);
      end
    end
    win_oh   = {{(N-1){1'b0}}, 1'b1} << win_idx;
    ptr_next = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= StIdle;
      Grant      <= '0;
      GrantValid <= 1'b0;
      GrantIdx   <= '0;
      Handover   <= 1'b0;
      ptr_q      <= '0;
      beat_q     <= '0;
    end else begin
      // Handover is a true pulse: it never stretches across a stall.
      Handover <= 1'b0;
      if (HREADY) begin
        unique case (state_q)
          StIdle: begin
            if (win_found) begin
              state_q    <= StOwned;
              Grant      <= win_oh;
              GrantValid <= 1'b1;
              GrantIdx   <= win_idx;
              ptr_q      <= ptr_next;
              beat_q     <= '0;
            end
          end
          StOwned: begin
            if (do_release) begin
              if (win_found) begin
                Grant    <= win_oh;
                GrantIdx <= win_idx;
                Handover <= 1'b1;
                ptr_q    <= ptr_next;
                beat_q   <= '0;
              end else begin
                state_q    <= StIdle;
                Grant      <= '0;
                GrantValid <= 1'b0;
                beat_q     <= '0;
              end
            end else if (beat_q != CntMax) begin
              beat_q <= beat_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/ahb_multi_arbiter.md
Name: ahb_multi_arbiter

Overview:
- Registered N-manager arbiter for the AHB multi-manager interconnect. It is the parametrised successor to the combinational LSB-first priority selector.
- Adds a selectable round-robin mode, grant holding across bursts and locked sequences, HREADY-qualified handover, and an optional beat-count fairness limit.
- Sits in front of the shared AHB address-phase mux. Grant/GrantIdx drive the mux select and HMASTER.

Parameters:
- N, 4, number of managers (N >= 2).
- MODE, 0, arbitration policy: 0 = fixed priority (index 0 highest), 1 = round-robin.
- MAXBEATS, 16, HREADY-qualified beats an owner may hold before a forced handover when others wait; 0 disables the limit.
- IDXW, $clog2(N), width of GrantIdx (derived; do not override).

Ports:
- HCLK  in  1  clock; all state updates on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- Req  in  N  per-manager request; held high while the manager wants the bus.
- Lock  in  N  per-manager HMASTLOCK; while the owner's bit is high, the grant cannot be taken away.
- HREADY  in  1  shared bus ready; the grant may change only on edges where HREADY=1.
- Grant  out  N  registered one-hot grant, or all zero when the bus is idle.
- GrantValid  out  1  registered; equals |Grant.
- GrantIdx  out  IDXW  registered binary index of the granted manager; holds its last value when idle.
- Handover  out  1  registered one-cycle pulse in the cycle after Grant changed from one non-zero owner to a different owner.

Behaviour:
- Reset (HRESETn low, asynchronous): Grant=0, GrantValid=0, GrantIdx=0, Handover=0, state=IDLE, rr pointer=0, beat counter=0.
  - Reset asserted mid-burst drops the grant immediately, with no wait for HREADY.
- Winner selection (combinational):
  - MODE 0: lowest-index set bit of Req.
  - MODE 1: lowest-index set bit of Req at index >= ptr. If there is none, lowest-index set bit of Req overall.
  - ptr updates to (granted index + 1) mod N on every new grant.
- State machine (all transitions require HREADY=1; with HREADY=0 every register holds):
  - IDLE:
    - If |Req, go to OWNED. Grant=onehot(winner), GrantIdx=winner.
    - Otherwise stay in IDLE. Grant-to-first-grant latency is 1 cycle.
  - OWNED, owner o:
    - Release when Req[o]=0 and Lock[o]=0.
    - Forced release when MAXBEATS!=0, beat counter has reached MAXBEATS-1, Lock[o]=0, and some other Req bit is set.
    - On release with other requests pending, grant the winner directly on the same edge: no idle bubble, Handover=1 next cycle. The winner excludes o on a forced release.
    - On release with no requests, go to IDLE and set Grant=0.
    - Otherwise hold.
- Beat counter:
  - Clears on every new grant.
  - Increments on each HREADY=1 cycle in OWNED.
  - Saturates at MAXBEATS-1.
- Lock priority: Lock[o]=1 overrides both Req[o]=0 and the MAXBEATS limit.
  - Lock on a manager that is not the owner has no effect.
- Boundary conditions:
  - All Req bits rising in the same cycle: exactly one grant.
  - ptr wraps from N-1 to 0.
  - Req of the owner dropping while HREADY=0: release is deferred to the first HREADY=1 edge.
- Invariant: Grant is one-hot or zero at all times, and GrantIdx matches Grant whenever GrantValid=1.

Test Plan:
- Reset/idle: N=4, MODE=0. Assert HRESETn low, then release with Req=0 -> Grant=0000, GrantValid=0, GrantIdx=0.
- Fixed priority: MODE=0, Req=1010, HREADY=1 -> next cycle Grant=0010, GrantIdx=1. Owner holds while Req[1]=1. Drop Req[1] -> Grant=1000 with Handover pulse.
- Round-robin rotation: MODE=1, Req=1111 held, owner releases by toggling its Req low for one cycle each turn -> grant sequence 0001, 0010, 0100, 1000, 0001 (ptr wrap).
- HREADY stall: owner 2 drops Req while HREADY=0 for 3 cycles -> Grant stays 0100 for all 3 cycles and changes on the first HREADY=1 edge.
- Fairness limit and lock: MAXBEATS=4, owner 0 holds Req with Req[3]=1 waiting -> after 4 ready beats Grant=1000. Repeat with Lock[0]=1 -> Grant stays 0001 until Lock[0] falls.
- Async reset mid-burst: Grant=0100 during a burst, HRESETn pulses low between clock edges -> Grant=0000 immediately. After release with Req=1111 in MODE=1 -> Grant=0001 (ptr reset to 0).
